// File: rtl/wb_pkg.sv
// Shared definitions for the BOOM L1 D-cache writeback unit.
//
// Contents:
//   wb_state_t      - writeback FSM state encoding
//   PROBE_ACK_DATA  - TileLink C opcode for probe-triggered writebacks (5)
//   RELEASE_DATA    - TileLink C opcode for voluntary evictions (7)
//   LINE_SIZE_LG    - log2 of the cache line size in bytes (64 B lines)
//   c_opcode()      - picks the C-channel opcode from the voluntary flag
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ     = 2'd1,
    S_SEND     = 2'd2,
    S_WAIT_ACK = 2'd3
  } wb_state_t;

  localparam logic [2:0] PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] RELEASE_DATA   = 3'd7;
  localparam int         LINE_SIZE_LG   = 6;

  function automatic logic [2:0] c_opcode(input logic voluntary);
    return voluntary ? RELEASE_DATA : PROBE_ACK_DATA;
  endfunction

endpackage

// File: rtl/wb_line_buffer.sv
// Line buffer for the writeback unit: BEATS x ROW_BITS register file.
// One synchronous write port, one asynchronous (combinational) read port so
// the C-channel beat data follows send_ctr in the same cycle.
//
// Ports:
//   clock  in   clock
//   we     in   write enable
//   waddr  in   write beat index
//   wdata  in   write data (one data-array row)
//   raddr  in   read beat index
//   rdata  out  read data, combinational from raddr
module wb_line_buffer #(
  parameter int ROW_BITS = 64,
  parameter int BEATS    = 8,
  localparam int AW      = $clog2(BEATS)
) (
  input  logic                clock,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [ROW_BITS-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [ROW_BITS-1:0] rdata
);

  logic [ROW_BITS-1:0] mem [BEATS];

  // Pure data storage: contents are only read after being written for the
  // current line, so no reset is needed.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boom_writeback_unit.sv
// BOOM L1 D-cache writeback unit.
//
// Accepts one writeback request (probe-triggered or voluntary eviction),
// reads the victim line beat by beat from the data array into a local line
// buffer, sends it on the TileLink C channel as ProbeAckData / ReleaseData,
// and for voluntary releases waits for the ReleaseAck on D.
//
// Build option: define BOOM_WB_STREAM_EN to overlap the read and send phases
// (a beat may be sent as soon as it has been captured). Default build buffers
// the whole line before the first C beat.
//
// Handshakes: every *_valid/*_ready pair transfers exactly on a cycle where
// both are high at the rising clock edge. A valid output, once raised, stays
// high with stable payload until it transfers; valid outputs never depend
// combinationally on the matching ready input.
//
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   req_*                    writeback request (valid/ready)
//   data_req_*               data array read request (valid/ready)
//   data_resp                read data, one cycle after a data_req transfer
//   rel_*                    TileLink C channel beat (valid/ready)
//   ack_valid, ack_ready     ReleaseAck on D (ready only in S_WAIT_ACK)
//   busy, busy_idx           unit active / set being written back
//   fsm_state                current FSM state, for observation
module boom_writeback_unit
  import wb_pkg::*;
#(
  parameter int NWAYS       = 4,
  parameter int IDX_BITS    = 6,
  parameter int TAG_BITS    = 20,
  parameter int ROW_BITS    = 64,
  parameter int BEATS       = 8,
  parameter int SOURCE_BITS = 4,
  parameter int ADDR_BITS   = 32,
  localparam int BEAT_BITS  = $clog2(BEATS),
  localparam int CTR_BITS   = BEAT_BITS + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  // writeback request
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SOURCE_BITS-1:0]        req_source,
  input  logic [IDX_BITS-1:0]           req_idx,
  input  logic [TAG_BITS-1:0]           req_tag,
  input  logic [2:0]                    req_param,
  input  logic [NWAYS-1:0]              req_way_en,
  input  logic                          req_voluntary,
  // data array read
  output logic                          data_req_valid,
  input  logic                          data_req_ready,
  output logic [NWAYS-1:0]              data_req_way_en,
  output logic [IDX_BITS+BEAT_BITS-1:0] data_req_addr,
  input  logic [ROW_BITS-1:0]           data_resp,
  // TileLink C channel
  output logic                          rel_valid,
  input  logic                          rel_ready,
  output logic [2:0]                    rel_opcode,
  output logic [2:0]                    rel_param,
  output logic [3:0]                    rel_size,
  output logic [SOURCE_BITS-1:0]        rel_source,
  output logic [ADDR_BITS-1:0]          rel_address,
  output logic [ROW_BITS-1:0]           rel_data,
  // ReleaseAck on D
  input  logic                          ack_valid,
  output logic                          ack_ready,
  // status
  output logic                          busy,
  output logic [IDX_BITS-1:0]           busy_idx,
  output wb_state_t                     fsm_state
);

  localparam logic [CTR_BITS-1:0] BEATS_C = CTR_BITS'(BEATS);
  localparam logic [CTR_BITS-1:0] LAST_C  = CTR_BITS'(BEATS - 1);

  wb_state_t               state;
  logic [CTR_BITS-1:0]     read_ctr;
  logic [CTR_BITS-1:0]     resp_ctr;
  logic [CTR_BITS-1:0]     send_ctr;
  logic                    resp_pending;

  // Fields latched at request acceptance
  logic [SOURCE_BITS-1:0]  source_q;
  logic [IDX_BITS-1:0]     idx_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic [2:0]              param_q;
  logic [NWAYS-1:0]        way_en_q;
  logic                    voluntary_q;

  logic                    req_fire;
  logic                    data_req_fire;
  logic                    rel_fire;
  logic                    buf_we;

  // ---------------------------------------------------------------------------
  // Output decode: everything below is a function of registered state only.
  // ---------------------------------------------------------------------------
  assign req_ready       = (state == S_IDLE);
  assign ack_ready       = (state == S_WAIT_ACK);
  assign busy            = (state != S_IDLE);
  assign busy_idx        = idx_q;
  assign fsm_state       = state;

  assign data_req_valid  = (state == S_READ) && (read_ctr < BEATS_C);
  assign data_req_way_en = way_en_q;
  assign data_req_addr   = {idx_q, read_ctr[BEAT_BITS-1:0]};

`ifdef BOOM_WB_STREAM_EN
  // A beat may leave as soon as it has been captured into the buffer.
  assign rel_valid = ((state == S_READ) || (state == S_SEND)) && (send_ctr < resp_ctr);
`else
  assign rel_valid = (state == S_SEND);
`endif

  assign rel_opcode  = c_opcode(voluntary_q);
  assign rel_param   = param_q;
  assign rel_size    = 4'(LINE_SIZE_LG);
  assign rel_source  = source_q;
  assign rel_address = ADDR_BITS'({tag_q, idx_q, {LINE_SIZE_LG{1'b0}}});

  assign req_fire      = req_valid && req_ready;
  assign data_req_fire = data_req_valid && data_req_ready;
  assign rel_fire      = rel_valid && rel_ready;

  // The data array answers exactly one cycle after a read transfer; the
  // pending flag marks the cycle on which data_resp belongs to this line.
  assign buf_we = (state == S_READ) && resp_pending;

  wb_line_buffer #(
    .ROW_BITS (ROW_BITS),
    .BEATS    (BEATS)
  ) u_line_buffer (
    .clock (clock),
    .we    (buf_we),
    .waddr (resp_ctr[BEAT_BITS-1:0]),
    .wdata (data_resp),
    .raddr (send_ctr[BEAT_BITS-1:0]),
    .rdata (rel_data)
  );

  // ---------------------------------------------------------------------------
  // Writeback FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      read_ctr     <= '0;
      resp_ctr     <= '0;
      send_ctr     <= '0;
      resp_pending <= 1'b0;
      source_q     <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      param_q      <= '0;
      way_en_q     <= '0;
      voluntary_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            source_q     <= req_source;
            idx_q        <= req_idx;
            tag_q        <= req_tag;
            param_q      <= req_param;
            way_en_q     <= req_way_en;
            voluntary_q  <= req_voluntary;
            read_ctr     <= '0;
            resp_ctr     <= '0;
            send_ctr     <= '0;
            resp_pending <= 1'b0;
            state        <= S_READ;
          end
        end

        S_READ: begin
          if (data_req_fire) begin
            read_ctr <= read_ctr + 1'b1;
          end
          resp_pending <= data_req_fire;
          if (resp_pending) begin
            resp_ctr <= resp_ctr + 1'b1;
            // Leave on the edge that captures the final beat, so the full
            // line is in the buffer by the first S_SEND cycle.
            if (resp_ctr == LAST_C) begin
              state <= S_SEND;
            end
          end
`ifdef BOOM_WB_STREAM_EN
          // The final beat is captured on the same edge that leaves S_READ,
          // so it can never be sent here; the last send always occurs in
          // S_SEND.
          if (rel_fire) begin
            send_ctr <= send_ctr + 1'b1;
          end
`endif
        end

        S_SEND: begin
          if (rel_fire) begin
            send_ctr <= send_ctr + 1'b1;
            if (send_ctr == LAST_C) begin
              state <= voluntary_q ? S_WAIT_ACK : S_IDLE;
            end
          end
        end

        S_WAIT_ACK: begin
          if (ack_valid) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boom_writeback_unit.sv
module tb_boom_writeback_unit;
  import wb_pkg::*;

  localparam int NWAYS = 4, IDX_BITS = 6, TAG_BITS = 20, ROW_BITS = 64;
  localparam int BEATS = 8, SOURCE_BITS = 4, ADDR_BITS = 32;
`ifdef BOOM_WB_STREAM_EN
  localparam int FIRST_GAP = 2;
`else
  localparam int FIRST_GAP = BEATS + 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                   req_valid, req_ready, req_voluntary;
  logic [SOURCE_BITS-1:0] req_source;
  logic [IDX_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [2:0]             req_param;
  logic [NWAYS-1:0]       req_way_en;
  logic                   data_req_valid, data_req_ready;
  logic [NWAYS-1:0]       data_req_way_en;
  logic [IDX_BITS+2:0]    data_req_addr;
  logic [ROW_BITS-1:0]    data_resp;
  logic                   rel_valid, rel_ready;
  logic [2:0]             rel_opcode, rel_param;
  logic [3:0]             rel_size;
  logic [SOURCE_BITS-1:0] rel_source;
  logic [ADDR_BITS-1:0]   rel_address;
  logic [ROW_BITS-1:0]    rel_data;
  logic                   ack_valid, ack_ready, busy;
  logic [IDX_BITS-1:0]    busy_idx;
  wb_state_t              fsm_state;

  boom_writeback_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source),
    .req_idx(req_idx), .req_tag(req_tag), .req_param(req_param),
    .req_way_en(req_way_en), .req_voluntary(req_voluntary),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_way_en(data_req_way_en), .data_req_addr(data_req_addr),
    .data_resp(data_resp),
    .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_opcode(rel_opcode),
    .rel_param(rel_param), .rel_size(rel_size), .rel_source(rel_source),
    .rel_address(rel_address), .rel_data(rel_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready),
    .busy(busy), .busy_idx(busy_idx), .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];       // expected rel_data per beat
  logic [45:0] exp_hdr_q[$];   // {opcode, param, size, source, address}
  logic [12:0] exp_dreq_q[$];  // {way_en, idx, beat}
  int beats_sent = 0;
  int cyc = 0;
  bit measure = 0;
  int first_fire_cyc = -1;
  int first_rel_cyc = -1;
  bit toggle_ready = 0;
  int stall_left = 0;
  int stall_at = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Line contents served by the data-array model: beat*0x1111 for set 0x12,
  // other sets get a distinct pattern in the upper bits.
  function automatic logic [63:0] line_data(input logic [5:0] idx, input logic [2:0] beat);
    logic [63:0] hi;
    hi = {58'h0, idx ^ 6'h12};
    return (64'(beat) * 64'h1111) ^ (hi << 40);
  endfunction

  // Data array model: answers exactly one cycle after a read transfer.
  always @(posedge clock) begin
    if (data_req_valid && data_req_ready)
      data_resp <= line_data(data_req_addr[8:3], data_req_addr[2:0]);
  end

  // Ready driver: optional toggling of data_req_ready, rel_ready stall.
  initial begin
    forever begin
      @(posedge clock); #1;
      data_req_ready = toggle_ready ? ~data_req_ready : 1'b1;
      if (stall_left > 0 && beats_sent == stall_at) begin
        rel_ready = 1'b0;
        stall_left--;
      end else begin
        rel_ready = 1'b1;
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        prev_stall = 0;
  logic [63:0] prev_data;
  logic [45:0] prev_hdr;
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (data_req_valid && data_req_ready) begin
        if (measure && first_fire_cyc < 0) first_fire_cyc = cyc;
        check("dreq_expected", 64'(exp_dreq_q.size() != 0), 64'd1);
        if (exp_dreq_q.size() != 0)
          check("dreq_addr", 64'({data_req_way_en, data_req_addr}), 64'(exp_dreq_q.pop_front()));
      end
      if (prev_stall) begin
        check("rel_valid_held", 64'(rel_valid), 64'd1);
        check("rel_data_stable", rel_data, prev_data);
        check("rel_hdr_stable", 64'({rel_opcode, rel_param, rel_size, rel_source, rel_address}), 64'(prev_hdr));
      end
      if (rel_valid) begin
        if (measure && first_rel_cyc < 0) first_rel_cyc = cyc;
        if (rel_ready) begin
          beats_sent++;
          check("rel_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            check("rel_data", rel_data, exp_q.pop_front());
            check("rel_hdr", 64'({rel_opcode, rel_param, rel_size, rel_source, rel_address}),
                  64'(exp_hdr_q.pop_front()));
          end
        end
      end
      prev_stall = rel_valid && !rel_ready;
      prev_data  = rel_data;
      prev_hdr   = {rel_opcode, rel_param, rel_size, rel_source, rel_address};
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic expect_line(input logic [3:0] src, input logic [5:0] idx, input logic [19:0] tag,
                             input logic [2:0] param, input logic [3:0] way, input logic vol);
    logic [2:0] op;
    op = vol ? 3'd7 : 3'd5;
    for (int b = 0; b < BEATS; b++) begin
      exp_dreq_q.push_back({way, idx, 3'(b)});
      exp_q.push_back(line_data(idx, 3'(b)));
      exp_hdr_q.push_back({op, param, 4'd6, src, tag, idx, 6'b0});
    end
  endtask

  task automatic drive_req(input logic [3:0] src, input logic [5:0] idx, input logic [19:0] tag,
                           input logic [2:0] param, input logic [3:0] way, input logic vol);
    @(posedge clock); #1;
    req_source = src; req_idx = idx; req_tag = tag;
    req_param = param; req_way_en = way; req_voluntary = vol;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int i;
    i = 0;
    @(negedge clock);
    while (!req_ready && i < 200) begin
      @(negedge clock);
      i++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 300 && beats_sent < target; i++) @(posedge clock);
    check("beats_done", 64'(beats_sent), 64'(target));
  endtask

  task automatic pulse_ack();
    @(posedge clock); #1 ack_valid = 1'b1;
    @(posedge clock); #1 ack_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int base;
  initial begin
    req_valid = 0; req_source = '0; req_idx = '0; req_tag = '0; req_param = '0;
    req_way_en = '0; req_voluntary = 0; data_req_ready = 1; data_resp = '0;
    rel_ready = 1; ack_valid = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_dreq_valid", 64'(data_req_valid), 64'd0);
    check("rst_rel_valid", 64'(rel_valid), 64'd0);
    check("rst_ack_ready", 64'(ack_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_busy_idx", 64'(busy_idx), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(S_IDLE));
    reset = 1'b1;

    // Probe writeback: opcode 5, address 0xABCDE480, data 0..0x7777
    base = beats_sent;
    measure = 1;
    expect_line(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b0);
    drive_req(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b0);
    wait_accept();
    @(negedge clock);
    check("probe_req_ready_low", 64'(req_ready), 64'd0);
    check("probe_busy_idx", 64'(busy_idx), 64'h12);
    wait_beats(base + 8);
    measure = 0;
    @(negedge clock);
    check("probe_idle_after", 64'(req_ready), 64'd1);
    check("probe_no_ack_wait", 64'(ack_ready), 64'd0);
    check("first_beat_gap", 64'(first_rel_cyc - first_fire_cyc), 64'(FIRST_GAP));

    // Voluntary release: opcode 7, hold until ReleaseAck; stray ack ignored
    base = beats_sent;
    expect_line(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b1);
    drive_req(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b1);
    wait_accept();
    @(posedge clock); #1 ack_valid = 1'b1;
    @(negedge clock);
    check("stray_ack_ready", 64'(ack_ready), 64'd0);
    @(posedge clock); #1 ack_valid = 1'b0;
    wait_beats(base + 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("vol_ack_ready", 64'(ack_ready), 64'd1);
      check("vol_req_ready", 64'(req_ready), 64'd0);
      check("vol_state", 64'(fsm_state), 64'(S_WAIT_ACK));
    end
    pulse_ack();
    @(negedge clock);
    check("vol_idle_after_ack", 64'(req_ready), 64'd1);
    check("vol_ack_ready_off", 64'(ack_ready), 64'd0);

    // Backpressure: data_req_ready toggling, rel_ready low 3 cycles at beat 4
    base = beats_sent;
    toggle_ready = 1;
    stall_at = base + 4;
    stall_left = 3;
    expect_line(4'h7, 6'h21, 20'h13579, 3'd2, 4'b0010, 1'b0);
    drive_req(4'h7, 6'h21, 20'h13579, 3'd2, 4'b0010, 1'b0);
    wait_accept();
    wait_beats(base + 8);
    toggle_ready = 0;
    check("bp_stall_consumed", 64'(stall_left), 64'd0);
    repeat (2) @(posedge clock);

    // Back-to-back: second request waits until the first line completes
    base = beats_sent;
    expect_line(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b0);
    expect_line(4'h9, 6'h2A, 20'h12345, 3'd2, 4'b0001, 1'b0);
    drive_req(4'h3, 6'h12, 20'hABCDE, 3'd1, 4'b0100, 1'b0);
    wait_accept();
    drive_req(4'h9, 6'h2A, 20'h12345, 3'd2, 4'b0001, 1'b0);
    @(negedge clock);
    check("b2b_blocked", 64'(req_ready), 64'd0);
    check("b2b_busy_idx_a", 64'(busy_idx), 64'h12);
    wait_accept();
    check("b2b_a_done_first", 64'(beats_sent), 64'(base + 8));
    @(negedge clock);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_busy_idx_b", 64'(busy_idx), 64'h2A);
    wait_beats(base + 16);
    repeat (2) @(posedge clock);

    // Reset during beat 3 of a probe writeback
    base = beats_sent;
    expect_line(4'h1, 6'h05, 20'h0F00D, 3'd0, 4'b1000, 1'b0);
    drive_req(4'h1, 6'h05, 20'h0F00D, 3'd0, 4'b1000, 1'b0);
    wait_accept();
    wait_beats(base + 3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rel_valid", 64'(rel_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete(); exp_hdr_q.delete(); exp_dreq_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    check("post_rst_dreq_valid", 64'(data_req_valid), 64'd0);
    check("post_rst_state", 64'(fsm_state), 64'(S_IDLE));
    check("post_rst_no_beats", 64'(beats_sent), 64'(base + 3));

    // Fresh line at the top set/tag after reset: reads start again at beat 0
    base = beats_sent;
    expect_line(4'hF, 6'h3F, 20'hFFFFF, 3'd5, 4'b0001, 1'b1);
    drive_req(4'hF, 6'h3F, 20'hFFFFF, 3'd5, 4'b0001, 1'b1);
    wait_accept();
    wait_beats(base + 8);
    @(negedge clock);
    check("edge_ack_ready", 64'(ack_ready), 64'd1);
    pulse_ack();
    @(negedge clock);
    check("edge_idle", 64'(req_ready), 64'd1);

    // Final report
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_dreq_drained", 64'(exp_dreq_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
